// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first unsigned adder (one bit per clock) with carry flop and done pulse.
// Defining SERIAL_ADDER_OVF_EN adds the ovf port holding the two's-complement overflow of the result.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             done,
    output logic             ovf
`else
    output logic             done
`endif
);

    localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_cout;

    // Single-bit full-add cell on the current LSBs and the running carry.
    assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
    assign w_cout = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            carry   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_c     <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_c   <= w_cout;
                    sum   <= {w_s, sum[WIDTH-1:1]};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        carry   <= w_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_c here is the carry into the MSB.
                        ovf     <= r_c ^ w_cout;
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven, hand-sequenced and random checks of serial_adder (WIDTH=8)
// against an arithmetic reference model.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             busy;
    logic             done;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .carry (carry),
        .busy  (busy),
`ifdef SERIAL_ADDER_OVF_EN
        .done  (done),
        .ovf   (ovf)
`else
        .done  (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer addition; signed overflow from operand/result signs.
    task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output logic [WIDTH-1:0] s, output logic c, output logic o);
        logic [WIDTH:0] full;
        full = {1'b0, x} + {1'b0, y};
        s = full[WIDTH-1:0];
        c = full[WIDTH];
        o = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endtask

    task automatic check_result(input string name, input logic [WIDTH-1:0] es,
                                input logic ec, input logic eo);
        check({name, ".sum"}, 32'(sum), 32'(es));
        check({name, ".carry"}, 32'(carry), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check({name, ".ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected x in expected ovf");
`endif
    endtask

    // Present operands with start for one edge; returns just after the accepting edge.
    task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
    endtask

    // Count edges until done rises (bounded); lat = edges after the accepting edge.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < int'(WIDTH) + 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        vec_t             vecs[$];
        vec_t             v;
        int               lat;
        int               seen;
        logic [WIDTH-1:0] es;
        logic             ec;
        logic             eo;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.sum", 32'(sum), 32'h0);
        check("reset.busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset release: everything stays at zero.
        repeat (5) begin
            @(posedge clk);
            #1;
            check("idle.outs", {22'h0, sum, carry, busy, done}, 32'h0);
`ifdef SERIAL_ADDER_OVF_EN
            check("idle.ovf", 32'(ovf), 32'h0);
`endif
        end

        vecs.push_back('{8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0});
        vecs.push_back('{8'h0F, 8'h01, 8'h10, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            v = vecs[i];
            launch(v.a, v.b);
            check("vec.busy_after_start", 32'(busy), 32'h1);
            wait_done(lat);
            check("vec.latency", 32'(lat), 32'(WIDTH));
            check("vec.busy_at_done", 32'(busy), 32'h0);
            check_result("vec", v.sum, v.carry, v.ovf);
            @(posedge clk);
            #1;
            check("vec.done_one_cycle", 32'(done), 32'h0);
            check("vec.sum_held", 32'(sum), 32'(v.sum));
        end

        // start re-asserted mid-shift with other operands must be ignored.
        launch(8'h35, 8'h4A);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h20;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        check("ign.latency", 32'(lat), 32'(WIDTH - 3));
        check_result("ign", 8'h7F, 1'b0, 1'b0);
        repeat (WIDTH + 2) begin
            @(posedge clk);
            #1;
            check("ign.no_second_op", {23'h0, sum, busy}, {23'h0, 8'h7F, 1'b0});
        end

        // Back-to-back: start held through busy and done; second result WIDTH+1 edges later.
        launch(8'h35, 8'h4A);
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        wait_done(lat);
        check("b2b.first_latency", 32'(lat), 32'(WIDTH));
        check_result("b2b.first", 8'h7F, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b.restart_busy", {30'h0, busy, done}, 32'h2);
        wait_done(lat);
        check("b2b.second_latency", 32'(lat + 1), 32'(WIDTH + 1));
        check_result("b2b.second", 8'h03, 1'b0, 1'b0);

        // Asynchronous reset mid-shift: immediate clear, aborted op never signals done.
        launch(8'h35, 8'h4A);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst.async_clear", {22'h0, sum, carry, busy, done}, 32'h0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst.ovf", 32'(ovf), 32'h0);
`endif
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (WIDTH + 4) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("rst.no_done", 32'(seen), 32'h0);
        launch(8'h0F, 8'h01);
        wait_done(lat);
        check("rst.fresh_latency", 32'(lat), 32'(WIDTH));
        check_result("rst.fresh", 8'h10, 1'b0, 1'b0);

        // Random operands vs. the arithmetic model.
        repeat (30) begin
            v.a = WIDTH'($urandom);
            v.b = WIDTH'($urandom);
            model(v.a, v.b, es, ec, eo);
            launch(v.a, v.b);
            wait_done(lat);
            check("rand.latency", 32'(lat), 32'(WIDTH));
            check_result("rand", es, ec, eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
